// File: rtl/prbs_checker.sv
// Serial PRBS checker: self-synchronises a local LFSR to the received stream,
// then flywheels it and counts bit errors against the prediction.
module prbs_checker #(
  parameter int               WIDTH      = 4,
  parameter logic [WIDTH-1:0] TAP_MASK   = 4'b1001,
  parameter int               LOCK_CNT   = 8,
  parameter int               UNLOCK_ERR = 3,
  parameter int               CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_in_valid,
  input  logic             i_in_bit,
  input  logic             i_clear_cnt,
  output logic             o_locked,
  output logic             o_err_pulse,
  output logic             o_lock_lost,
  output logic [CNT_W-1:0] o_err_cnt
);

  localparam int FILL_W = $clog2(WIDTH + 1);
  localparam int MCNT_W = $clog2(LOCK_CNT + 1);
  localparam int ECNT_W = $clog2(UNLOCK_ERR + 1);

  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(WIDTH);
  localparam logic [MCNT_W-1:0] MCNT_LAST = MCNT_W'(LOCK_CNT - 1);
  localparam logic [ECNT_W-1:0] ECNT_LAST = ECNT_W'(UNLOCK_ERR - 1);

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t             r_state, w_state_next;
  logic [WIDTH-1:0]   r_hist, w_hist_next;
  logic [FILL_W-1:0]  r_fill, w_fill_next;
  logic [MCNT_W-1:0]  r_mcnt, w_mcnt_next;
  logic [ECNT_W-1:0]  r_ecnt, w_ecnt_next;
  logic [CNT_W-1:0]   r_err_cnt, w_err_cnt_next;
  logic               r_locked, w_locked_next;
  logic               r_err_pulse, w_err_pulse_next;
  logic               r_lock_lost, w_lock_lost_next;
  logic               w_pred;

  assign w_pred = ^(r_hist & TAP_MASK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= SEARCH;
      r_hist      <= '0;
      r_fill      <= '0;
      r_mcnt      <= '0;
      r_ecnt      <= '0;
      r_err_cnt   <= '0;
      r_locked    <= 1'b0;
      r_err_pulse <= 1'b0;
      r_lock_lost <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_hist      <= w_hist_next;
      r_fill      <= w_fill_next;
      r_mcnt      <= w_mcnt_next;
      r_ecnt      <= w_ecnt_next;
      r_err_cnt   <= w_err_cnt_next;
      r_locked    <= w_locked_next;
      r_err_pulse <= w_err_pulse_next;
      r_lock_lost <= w_lock_lost_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_hist_next      = r_hist;
    w_fill_next      = r_fill;
    w_mcnt_next      = r_mcnt;
    w_ecnt_next      = r_ecnt;
    w_err_cnt_next   = r_err_cnt;
    w_err_pulse_next = 1'b0;
    w_lock_lost_next = 1'b0;

    if (i_in_valid) begin
      case (r_state)
        SEARCH: begin
          // Self-sync: the window is loaded from received data, not the prediction.
          w_hist_next = {r_hist[WIDTH-2:0], i_in_bit};
          if (r_fill != FILL_FULL) begin
            w_fill_next = r_fill + FILL_W'(1);
          end else if ((i_in_bit == w_pred) && (r_hist != '0)) begin
            if (r_mcnt == MCNT_LAST) begin
              w_state_next = LOCKED;
              w_mcnt_next  = '0;
            end else begin
              w_mcnt_next = r_mcnt + MCNT_W'(1);
            end
          end else begin
            w_mcnt_next = '0;
          end
        end
        LOCKED: begin
          // Flywheel: a corrupted received bit never enters the window.
          w_hist_next = {r_hist[WIDTH-2:0], w_pred};
          if (i_in_bit != w_pred) begin
            w_err_pulse_next = 1'b1;
            if (r_err_cnt != '1) begin
              w_err_cnt_next = r_err_cnt + CNT_W'(1);
            end
            if (r_ecnt == ECNT_LAST) begin
              w_state_next     = SEARCH;
              w_ecnt_next      = '0;
              w_mcnt_next      = '0;
              w_lock_lost_next = 1'b1;
            end else begin
              w_ecnt_next = r_ecnt + ECNT_W'(1);
            end
          end else begin
            w_ecnt_next = '0;
          end
        end
        default: w_state_next = SEARCH;
      endcase
    end

    if (i_clear_cnt) begin
      w_err_cnt_next = '0;
    end

    w_locked_next = (w_state_next == LOCKED);
  end

  assign o_locked    = r_locked;
  assign o_err_pulse = r_err_pulse;
  assign o_lock_lost = r_lock_lost;
  assign o_err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker: lock, flywheel, unlock/relock, all-zero input,
// gapped valid, clear priority, async reset and counter saturation.
module tb_prbs_checker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_bit = 1'b0;
  logic        clear_cnt = 1'b0;
  logic        locked, err_pulse, lock_lost;
  logic [15:0] err_cnt;
  logic        locked2, err_pulse2, lock_lost2;
  logic [1:0]  err_cnt2;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  prbs_checker dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_in_valid  (in_valid),
    .i_in_bit    (in_bit),
    .i_clear_cnt (clear_cnt),
    .o_locked    (locked),
    .o_err_pulse (err_pulse),
    .o_lock_lost (lock_lost),
    .o_err_cnt   (err_cnt)
  );

  prbs_checker #(.CNT_W(2)) dut_sat (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_in_valid  (in_valid),
    .i_in_bit    (in_bit),
    .i_clear_cnt (clear_cnt),
    .o_locked    (locked2),
    .o_err_pulse (err_pulse2),
    .o_lock_lost (lock_lost2),
    .o_err_cnt   (err_cnt2)
  );

  typedef struct {
    logic        valid;
    logic        bitv;
    logic        clr;
    logic        e_locked;
    logic        e_pulse;
    logic        e_lost;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[30];

  // Default generator stream, period 15, seeded 4'b0001.
  function automatic logic sbit(input int k);
    logic [14:0] p;
    p = 15'b000111101011001;
    return p[14 - (k % 15)];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", name, act, exp);
  endtask

  task automatic step(input logic v, input logic b, input logic c);
    in_valid  = v;
    in_bit    = b;
    clear_cnt = c;
    @(posedge clk);
    #1;
    $display("t=%0t v=%0b b=%0b clr=%0b -> locked=%0b pulse=%0b lost=%0b cnt=%0d sat_cnt=%0d",
             $time, v, b, c, locked, err_pulse, lock_lost, err_cnt, err_cnt2);
  endtask

  task automatic expect_out(input string tag, input int k, input logic el, input logic ep,
                            input logic ell, input logic [15:0] ec);
    chk($sformatf("%s[%0d].locked", tag, k), 32'(locked), 32'(el));
    chk($sformatf("%s[%0d].err_pulse", tag, k), 32'(err_pulse), 32'(ep));
    chk($sformatf("%s[%0d].lock_lost", tag, k), 32'(lock_lost), 32'(ell));
    chk($sformatf("%s[%0d].err_cnt", tag, k), 32'(err_cnt), 32'(ec));
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_bit    = 1'b0;
    clear_cnt = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic b;
    logic el;
    logic [15:0] ec;
    logic [1:0]  ec2;

    // 4 fill bits + 8 matches: locked is first seen after bit index 11.
    for (int i = 0; i < 30; i++) begin
      vecs[i].valid    = 1'b1;
      vecs[i].bitv     = sbit(i);
      vecs[i].clr      = 1'b0;
      vecs[i].e_locked = (i >= 11);
      vecs[i].e_pulse  = 1'b0;
      vecs[i].e_lost   = 1'b0;
      vecs[i].e_cnt    = 16'd0;
    end

    do_reset();
    expect_out("reset", 0, 1'b0, 1'b0, 1'b0, 16'd0);

    // Clean stream lock
    for (int i = 0; i < 30; i++) begin
      step(vecs[i].valid, vecs[i].bitv, vecs[i].clr);
      expect_out("lock", i, vecs[i].e_locked, vecs[i].e_pulse, vecs[i].e_lost, vecs[i].e_cnt);
    end

    // Single flipped bit while locked; clear the count on the last clean bit
    do_reset();
    for (int k = 0; k < 40; k++) begin
      b = sbit(k) ^ (k == 20);
      step(1'b1, b, k == 39);
      expect_out("single", k, k >= 11, k == 20, 1'b0, (k >= 20 && k < 39) ? 16'd1 : 16'd0);
    end

    // Three consecutive errors drop lock, then 8 good bits relock
    for (int k = 40; k <= 50; k++) begin
      b  = sbit(k) ^ (k <= 42);
      el = (k < 42) || (k >= 50);
      ec = (k == 40) ? 16'd1 : (k == 41) ? 16'd2 : 16'd3;
      step(1'b1, b, 1'b0);
      expect_out("burst", k, el, k <= 42, k == 42, ec);
    end
    chk("sat.after_burst", 32'(err_cnt2), 32'd3);

    // Isolated errors keep lock; saturation; clear beats a same-cycle error
    for (int k = 51; k <= 58; k++) begin
      b = sbit(k) ^ (k == 53 || k == 55 || k == 56 || k == 58);
      case (k)
        53, 54:  begin ec = 16'd4; ec2 = 2'd3; end
        55:      begin ec = 16'd5; ec2 = 2'd3; end
        56, 57:  begin ec = 16'd0; ec2 = 2'd0; end
        58:      begin ec = 16'd1; ec2 = 2'd1; end
        default: begin ec = 16'd3; ec2 = 2'd3; end
      endcase
      step(1'b1, b, k == 56);
      expect_out("iso", k, 1'b1, (k == 53 || k == 55 || k == 56 || k == 58), 1'b0, ec);
      chk($sformatf("sat[%0d].err_cnt", k), 32'(err_cnt2), 32'(ec2));
    end

    // Invalid cycle: pulses drop, state holds
    step(1'b0, 1'b0, 1'b0);
    expect_out("idle", 59, 1'b1, 1'b0, 1'b0, 16'd1);

    // Async reset mid-lock, checked before any clock edge
    step(1'b1, sbit(59) ^ 1'b1, 1'b0);
    expect_out("pre_rst", 60, 1'b1, 1'b1, 1'b0, 16'd2);
    #2;
    rst_n = 1'b0;
    #1;
    expect_out("async_rst", 0, 1'b0, 1'b0, 1'b0, 16'd0);
    chk("async_rst.sat_cnt", 32'(err_cnt2), 32'd0);
    chk("async_rst.sat_locked", 32'(locked2), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // All-zero window never qualifies as a match
    for (int k = 0; k < 40; k++) begin
      step(1'b1, 1'b0, 1'b0);
      expect_out("zeros", k, 1'b0, 1'b0, 1'b0, 16'd0);
    end

    // Gapped valid: same lock point counted in accepted bits
    do_reset();
    for (int k = 0; k < 30; k++) begin
      step(1'b1, sbit(k), 1'b0);
      expect_out("gap_v", k, k >= 11, 1'b0, 1'b0, 16'd0);
      step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
      expect_out("gap_i", k, k >= 11, 1'b0, 1'b0, 16'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
